// File: rtl/prng_pkg.sv
// Shared constants and FSM encoding for the PRNG word stream.
package prng_pkg;

    localparam int DefLength = 48;
    localparam int DefWidth  = 8;
    localparam int MinLength = 2;
    localparam int MaxLength = 64;

    // Stored at the widest legal length; instances truncate to their own Length.
    localparam logic [MaxLength-1:0] DefTaps = 64'h0000_8000_0000_005C;
    localparam logic [MaxLength-1:0] DefSeed = 64'h0000_A1EA_1AC7_AE57;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/prng_stream_if.sv
// Valid/ready word stream plus seed-load controls for prng_stream.
interface prng_stream_if #(
    parameter int Length = 48,
    parameter int Width  = 8
);

    logic              LOAD;
    logic [Length-1:0] SEED_IN;
    logic              READY;
    logic              VALID;
    logic [Width-1:0]  DATA;
    logic              LOCKUP;

    modport master (
        input  LOAD,
        input  SEED_IN,
        input  READY,
        output VALID,
        output DATA,
        output LOCKUP
    );

    modport slave (
        output LOAD,
        output SEED_IN,
        output READY,
        input  VALID,
        input  DATA,
        input  LOCKUP
    );

endinterface

// File: rtl/prng_step.sv
// Combinational Width-step unroll of the Fibonacci shift register.
module prng_step
    import prng_pkg::*;
#(
    parameter int                Length = DefLength,
    parameter int                Width  = DefWidth,
    parameter logic [Length-1:0] Taps   = Length'(DefTaps)
) (
    input  logic [Length-1:0] cur,
    output logic [Length-1:0] nxt,
    output logic [Width-1:0]  word
);

    logic [Length-1:0] s;

    always_comb begin
        s = cur;
        for (int i = 0; i < Width; i++) begin
            s = {s[Length-2:0], ^(s & Taps)};
        end
        nxt = s;
    end

    // The top Width bits are exactly the serial bits the next Width steps shift out.
    assign word = cur[Length-1 -: Width];

endmodule

// File: rtl/prng_stream.sv
// Word-parallel LFSR stream with valid/ready output and synchronous seed load.
// Optional all-zero state recovery is enabled by defining PRNG_STREAM_LOCKUP_EN.
module prng_stream
    import prng_pkg::*;
#(
    parameter int                Length = DefLength,
    parameter int                Width  = DefWidth,
    parameter logic [Length-1:0] Taps   = Length'(DefTaps),
    parameter logic [Length-1:0] Seed   = Length'(DefSeed)
) (
    input logic           CLK,
    input logic           RST_N,
    prng_stream_if.master bus
);

    state_t            state;
    state_t            state_nxt;
    logic [Length-1:0] bits;
    logic [Length-1:0] bits_step;
    logic [Width-1:0]  word;
    logic [Width-1:0]  data_r;
    logic              advance;
    logic              take_word;
    logic              reload_seed;

    prng_step #(
        .Length (Length),
        .Width  (Width),
        .Taps   (Taps)
    ) u_step (
        .cur  (bits),
        .nxt  (bits_step),
        .word (word)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.LOAD || reload_seed) begin
            state_nxt = FILL;
        end else if (take_word) begin
            state_nxt = RUN;
        end
    end

    // FILL always produces; RUN produces only when the held word is accepted.
    always_comb begin
        advance = (state == FILL) || bus.READY;
`ifdef PRNG_STREAM_LOCKUP_EN
        reload_seed = !bus.LOAD && advance && (bits == '0);
`else
        reload_seed = 1'b0;
`endif
        take_word = !bus.LOAD && advance && !reload_seed;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bits   <= Seed;
            data_r <= '0;
        end else if (bus.LOAD) begin
            bits <= bus.SEED_IN;
        end else if (reload_seed) begin
            bits <= Seed;
        end else if (take_word) begin
            bits   <= bits_step;
            data_r <= word;
        end
    end

    assign bus.VALID = (state == RUN);
    assign bus.DATA  = data_r;

`ifdef PRNG_STREAM_LOCKUP_EN
    logic lockup_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lockup_r <= 1'b0;
        end else begin
            lockup_r <= reload_seed;
        end
    end

    assign bus.LOCKUP = lockup_r;
`else
    assign bus.LOCKUP = 1'b0;
`endif

endmodule

// File: tb/tb_prng_stream.sv
// Bench for prng_stream: directed table on a 4-bit instance, golden serial stream,
// randomized traffic against a serial-generator model, and asynchronous reset.
module tb_prng_stream;
    import prng_pkg::*;

`ifdef PRNG_STREAM_LOCKUP_EN
    localparam bit LockupEn = 1'b1;
`else
    localparam bit LockupEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prng_stream_if #(.Length(4),  .Width(4)) if_s ();
    prng_stream_if #(.Length(48), .Width(1)) if_b ();
    prng_stream_if #(.Length(48), .Width(8)) if_r ();

    prng_stream #(.Length(4), .Width(4), .Taps(4'b1001), .Seed(4'b0001)) u_s (
        .CLK(clk), .RST_N(rst_n), .bus(if_s));
    prng_stream #(.Width(1)) u_b (
        .CLK(clk), .RST_N(rst_n), .bus(if_b));
    prng_stream u_r (
        .CLK(clk), .RST_N(rst_n), .bus(if_r));

    typedef struct {
        logic       ready;
        logic       load;
        logic [3:0] seed;
        logic       vld;
        logic       chk_data;
        logic [3:0] data;
        logic       lockup;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic [3:0] s,
                                input logic v, input logic cd, input logic [3:0] d,
                                input logic lk);
        vec_t t;
        t.ready = r; t.load = l; t.seed = s;
        t.vld = v; t.chk_data = cd; t.data = d; t.lockup = lk;
        return t;
    endfunction

    // Single-bit generator: shift left, new LSB is the parity of the tapped bits.
    function automatic logic [63:0] gen_step(input logic [63:0] st, input int len,
                                             input logic [63:0] taps);
        logic [63:0] mask;
        logic        fb;
        mask = (len == 64) ? '1 : ((64'd1 << len) - 64'd1);
        fb   = ($countones(st & taps) % 2) == 1;
        return ((st << 1) | 64'(fb)) & mask;
    endfunction

    function automatic logic gen_out(input logic [63:0] st, input int len);
        return st[len-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] g;
        logic [63:0] m_st;
        logic [63:0] rnd;
        logic [7:0]  m_data;
        logic        m_valid;
        logic        m_lock;
        logic        ld;
        logic        rdy;
        logic [47:0] sd;

        // Words from seed 0001 taps 1001 follow the serial order 0001 1110 1011 0010 ...
        tbl[0] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
        for (int i = 1; i <= 5; i++) tbl[i] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hB, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
`ifdef PRNG_STREAM_LOCKUP_EN
        tbl[14] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0);
`else
        tbl[14] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0);
`endif

        if_s.LOAD = 1'b0; if_s.SEED_IN = '0; if_s.READY = 1'b0;
        if_b.LOAD = 1'b0; if_b.SEED_IN = '0; if_b.READY = 1'b0;
        if_r.LOAD = 1'b0; if_r.SEED_IN = '0; if_r.READY = 1'b0;

        #12;
        chk("reset.s.valid",  64'(if_s.VALID),  64'd0);
        chk("reset.s.data",   64'(if_s.DATA),   64'd0);
        chk("reset.s.lockup", 64'(if_s.LOCKUP), 64'd0);
        chk("reset.r.valid",  64'(if_r.VALID),  64'd0);
        chk("reset.r.data",   64'(if_r.DATA),   64'd0);
        rst_n = 1'b1;
        #1;
        chk("release.s.valid", 64'(if_s.VALID), 64'd0);

        for (int i = 0; i < 17; i++) begin
            if_s.READY   = tbl[i].ready;
            if_s.LOAD    = tbl[i].load;
            if_s.SEED_IN = tbl[i].seed;
            step();
            chk($sformatf("tbl%0d.valid", i), 64'(if_s.VALID), 64'(tbl[i].vld));
            if (tbl[i].chk_data)
                chk($sformatf("tbl%0d.data", i), 64'(if_s.DATA), 64'(tbl[i].data));
            chk($sformatf("tbl%0d.lockup", i), 64'(if_s.LOCKUP), 64'(tbl[i].lockup));
        end
        if_s.READY = 1'b0;

        // Width=1 instance has held its first bit since the first edge after reset.
        chk("bits.valid", 64'(if_b.VALID), 64'd1);
        g = DefSeed;
        for (int k = 0; k < 1000; k++) begin
            chk($sformatf("bit%0d", k), 64'(if_b.DATA), 64'(gen_out(g, 48)));
            g = gen_step(g, 48, DefTaps);
            if_b.READY = 1'b1;
            step();
        end
        if_b.READY = 1'b0;

        // Width=8 instance: model holds the serial generator state and the offered word.
        m_st   = DefSeed;
        m_data = '0;
        for (int b = 0; b < 8; b++) begin
            m_data = {m_data[6:0], gen_out(m_st, 48)};
            m_st   = gen_step(m_st, 48, DefTaps);
        end
        m_valid = 1'b1;
        chk("rand.first", 64'(if_r.DATA), 64'(m_data));
        for (int c = 0; c < 400; c++) begin
            ld  = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rnd = {$urandom(), $urandom()};
            sd  = ($urandom_range(0, 7) == 0) ? 48'd0 : rnd[47:0];
            if_r.LOAD    = ld;
            if_r.READY   = rdy;
            if_r.SEED_IN = sd;
            m_lock = 1'b0;
            if (ld) begin
                m_st    = 64'(sd);
                m_valid = 1'b0;
            end else if (!m_valid || rdy) begin
                if (LockupEn && m_st == 64'd0) begin
                    m_st    = DefSeed;
                    m_valid = 1'b0;
                    m_lock  = 1'b1;
                end else begin
                    for (int b = 0; b < 8; b++) begin
                        m_data = {m_data[6:0], gen_out(m_st, 48)};
                        m_st   = gen_step(m_st, 48, DefTaps);
                    end
                    m_valid = 1'b1;
                end
            end
            step();
            chk($sformatf("rand%0d.valid", c), 64'(if_r.VALID), 64'(m_valid));
            if (m_valid)
                chk($sformatf("rand%0d.data", c), 64'(if_r.DATA), 64'(m_data));
            chk($sformatf("rand%0d.lockup", c), 64'(if_r.LOCKUP), 64'(m_lock));
        end
        if_r.LOAD  = 1'b0;
        if_r.READY = 1'b0;

        // Asynchronous reset between edges while a word is offered.
        if_s.READY = 1'b1;
        step();
        chk("arst.pre.valid", 64'(if_s.VALID), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.s.valid",  64'(if_s.VALID),  64'd0);
        chk("arst.s.data",   64'(if_s.DATA),   64'd0);
        chk("arst.s.lockup", 64'(if_s.LOCKUP), 64'd0);
        chk("arst.r.valid",  64'(if_r.VALID),  64'd0);
        chk("arst.r.data",   64'(if_r.DATA),   64'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("arst.release.valid", 64'(if_s.VALID), 64'd0);
        step();
        chk("arst.first.valid", 64'(if_s.VALID), 64'd1);
        chk("arst.first.s",     64'(if_s.DATA),  64'h1);
        chk("arst.first.r",     64'(if_r.DATA),  64'hA1);
        chk("arst.first.b",     64'(if_b.DATA),  64'h1);
        step();
        chk("arst.second.s",    64'(if_s.DATA),  64'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
